ddr3_mem_arbiter: RTL and testbench

//  Two-port round-robin arbiter sharing the single 128-bit request port of ddr3_core between requesters.

---
 rtl/ddr3_mem_arbiter_if.sv | 50 +++++
 rtl/ddr3_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_ddr3_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_mem_arbiter_if.sv
// Bundle of the two requester ports and the ddr3_core request/response port.
// DDR3_ARB_STATS_EN adds the grant and stall counters to the bundle.
interface ddr3_mem_arbiter_if;
   logic [1:0][15:0]  wr;
   logic [1:0]        rd;
   logic [1:0][31:0]  addr;
   logic [1:0][127:0] write_data;
   logic [1:0][15:0]  req_id;
   logic [1:0]        accept;
   logic [1:0]        ack;
   logic [1:0]        error;
   logic [1:0][15:0]  resp_id;
   logic [1:0][127:0] read_data;

   logic [15:0]       mem_wr;
   logic              mem_rd;
   logic [31:0]       mem_addr;
   logic [127:0]      mem_write_data;
   logic [15:0]       mem_req_id;
   logic              mem_accept;
   logic              mem_ack;
   logic              mem_error;
   logic [15:0]       mem_resp_id;
   logic [127:0]      mem_read_data;

`ifdef DDR3_ARB_STATS_EN
   logic [1:0][31:0]  grants;
   logic [31:0]       stall_cycles;
`endif

   modport slave (
      input  wr, rd, addr, write_data, req_id,
      input  mem_accept, mem_ack, mem_error, mem_resp_id, mem_read_data,
`ifdef DDR3_ARB_STATS_EN
      output grants, stall_cycles,
`endif
      output accept, ack, error, resp_id, read_data,
      output mem_wr, mem_rd, mem_addr, mem_write_data, mem_req_id
   );

   modport master (
      output wr, rd, addr, write_data, req_id,
      output mem_accept, mem_ack, mem_error, mem_resp_id, mem_read_data,
`ifdef DDR3_ARB_STATS_EN
      input  grants, stall_cycles,
`endif
      input  accept, ack, error, resp_id, read_data,
      input  mem_wr, mem_rd, mem_addr, mem_write_data, mem_req_id
   );
endinterface

// File: rtl/ddr3_mem_arbiter.sv
// Two-port round-robin arbiter in front of the ddr3_core request port, with outstanding limit.
// Optional DDR3_ARB_STATS_EN adds per-port grant counters and an outstanding-stall counter.
//
// state | meaning
// IDLE  | no request held; may grant a valid port if below the outstanding limit
// REQ   | captured request presented on mem_*, waiting for mem_accept
module ddr3_mem_arbiter #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int OUT_W           = 3
) (
   input logic               clock,
   input logic               reset_n,
   ddr3_mem_arbiter_if.slave bus
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t           state, state_nxt;
   logic             last;
   logic [OUT_W-1:0] outstanding;
   logic [1:0]       valid;
   logic [1:0]       accept;
   logic             eligible;
   logic             grant_any;
   logic             grant_port;
   logic             inc;
   logic             dec;
   logic             unused_id_msb;

   assign valid[0]      = bus.rd[0] | (|bus.wr[0]);
   assign valid[1]      = bus.rd[1] | (|bus.wr[1]);
   assign eligible      = outstanding < OUT_W'(MAX_OUTSTANDING);
   assign unused_id_msb = bus.req_id[0][15] ^ bus.req_id[1][15];

   always_comb begin
      state_nxt  = state;
      grant_any  = 1'b0;
      grant_port = 1'b0;
      accept     = 2'b00;
      case (state)
         IDLE: begin
            if (eligible && (|valid)) begin
               grant_any          = 1'b1;
               // on a tie the port that did not win last time goes first
               grant_port         = (valid == 2'b11) ? ~last : valid[1];
               accept[grant_port] = 1'b1;
               state_nxt          = REQ;
            end
         end
         REQ: begin
            if (bus.mem_accept) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.accept = accept;
   assign inc        = (state == REQ) && bus.mem_accept;
   assign dec        = bus.mem_ack && (outstanding != '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         last        <= 1'b1;
         outstanding <= '0;
      end else begin
         state <= state_nxt;
         if (grant_any) last <= grant_port;
         case ({inc, dec})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.mem_wr         <= '0;
         bus.mem_rd         <= 1'b0;
         bus.mem_addr       <= '0;
         bus.mem_write_data <= '0;
         bus.mem_req_id     <= '0;
      end else if (grant_any) begin
         bus.mem_wr         <= bus.wr[grant_port];
         // a nonzero mask turns a combined rd+wr request into a write
         bus.mem_rd         <= bus.rd[grant_port] & ~(|bus.wr[grant_port]);
         bus.mem_addr       <= bus.addr[grant_port];
         bus.mem_write_data <= bus.write_data[grant_port];
         bus.mem_req_id     <= {grant_port, bus.req_id[grant_port][14:0]};
      end else if (inc) begin
         bus.mem_wr <= '0;
         bus.mem_rd <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.ack       <= '0;
         bus.error     <= '0;
         bus.resp_id   <= '0;
         bus.read_data <= '0;
      end else begin
         bus.ack <= {bus.mem_ack & bus.mem_resp_id[15], bus.mem_ack & ~bus.mem_resp_id[15]};
         if (bus.mem_ack) begin
            bus.error     <= {2{bus.mem_error}};
            bus.resp_id   <= {2{1'b0, bus.mem_resp_id[14:0]}};
            bus.read_data <= {2{bus.mem_read_data}};
         end
      end
   end

`ifdef DDR3_ARB_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.grants       <= '0;
         bus.stall_cycles <= '0;
      end else begin
         if (grant_any) bus.grants[grant_port] <= bus.grants[grant_port] + 32'd1;
         if ((state == IDLE) && (|valid) && !eligible) bus.stall_cycles <= bus.stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ddr3_mem_arbiter.sv
// Bench for ddr3_mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of grants, captured requests, outstanding count and responses.
module tb_ddr3_mem_arbiter;

   localparam int MAX = 4;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   ddr3_mem_arbiter_if bus();

   ddr3_mem_arbiter #(.MAX_OUTSTANDING(MAX), .OUT_W(3)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   // model state
   bit           m_busy;
   bit           m_last;
   int           m_out;
   logic [15:0]  e_wr;
   logic         e_rd;
   logic [31:0]  e_addr;
   logic [127:0] e_wd;
   logic [15:0]  e_id;
   logic [1:0]   e_ack;
   logic [1:0]   e_err;
   logic [15:0]  e_rid   [2];
   logic [127:0] e_rdata [2];
`ifdef DDR3_ARB_STATS_EN
   logic [31:0]  m_grants [2];
   logic [31:0]  m_stall;
`endif

   function automatic void model_reset();
      m_busy = 0; m_last = 1; m_out = 0;
      e_wr = '0; e_rd = 0; e_addr = '0; e_wd = '0; e_id = '0;
      e_ack = '0; e_err = '0;
      for (int i = 0; i < 2; i++) begin e_rid[i] = '0; e_rdata[i] = '0; end
`ifdef DDR3_ARB_STATS_EN
      m_grants[0] = '0; m_grants[1] = '0; m_stall = '0;
`endif
   endfunction

   logic [1:0] cv, cea;
   logic       cg;
   bit         c_busy_old;
   int         c_out_old;

   always @(negedge clock) begin
      if (!reset_n) begin
         model_reset();
      end else begin
         cv[0] = bus.rd[0] | (|bus.wr[0]);
         cv[1] = bus.rd[1] | (|bus.wr[1]);
         cea = 2'b00;
         cg  = 1'b0;
         if (!m_busy && m_out < MAX && cv != 2'b00) begin
            cg = (cv == 2'b11) ? ~m_last : cv[1];
            cea[cg] = 1'b1;
         end
         chk("accept", bus.accept, cea);
         chk("mem_req", {bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_write_data, bus.mem_req_id},
             {e_wr, e_rd, e_addr, e_wd, e_id});
         for (int n = 0; n < 2; n++)
            chk(n == 0 ? "resp_p0" : "resp_p1",
                {bus.ack[n], bus.error[n], bus.resp_id[n], bus.read_data[n]},
                {e_ack[n], e_err[n], e_rid[n], e_rdata[n]});
`ifdef DDR3_ARB_STATS_EN
         chk("stats", {bus.grants, bus.stall_cycles}, {m_grants[1], m_grants[0], m_stall});
         if (cea != 2'b00) m_grants[cg] = m_grants[cg] + 32'd1;
         if (!m_busy && cv != 2'b00 && m_out == MAX) m_stall = m_stall + 32'd1;
`endif
         c_busy_old = m_busy;
         c_out_old  = m_out;
         if (cea != 2'b00) begin
            e_wr   = bus.wr[cg];
            e_rd   = bus.rd[cg] & ~(|bus.wr[cg]);
            e_addr = bus.addr[cg];
            e_wd   = bus.write_data[cg];
            e_id   = {cg, bus.req_id[cg][14:0]};
            m_last = cg;
            m_busy = 1;
         end else if (c_busy_old && bus.mem_accept) begin
            e_wr = '0; e_rd = 0; m_busy = 0;
         end
         m_out = c_out_old + ((c_busy_old && bus.mem_accept) ? 1 : 0)
                           - ((bus.mem_ack && c_out_old > 0) ? 1 : 0);
         e_ack = 2'b00;
         if (bus.mem_ack) begin
            e_ack[bus.mem_resp_id[15]] = 1'b1;
            e_err = {2{bus.mem_error}};
            for (int n = 0; n < 2; n++) begin
               e_rid[n]   = {1'b0, bus.mem_resp_id[14:0]};
               e_rdata[n] = bus.mem_read_data;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      for (int n = 0; n < 2; n++) begin
         bus.rd[n] = 0; bus.wr[n] = '0; bus.addr[n] = '0;
         bus.write_data[n] = '0; bus.req_id[n] = '0;
      end
      bus.mem_accept = 0; bus.mem_ack = 0; bus.mem_error = 0;
      bus.mem_resp_id = '0; bus.mem_read_data = '0;
   endtask

   task automatic do_reset();
      reset_n = 0;
      clear_inputs();
      tick();
      tick();
      reset_n = 1;
   endtask

   localparam logic [127:0] RD0 = 128'hfeedface_01234567_89abcdef_cafef00d;
   localparam logic [127:0] WD1 = 128'hffeeddcc_bbaa9988_77665544_33221100;

   bit         tie_q[$];
   logic [15:0] seen_p1_id;
   int         cnt;
   bit         first_port;
   logic [1:0] acc;
   bit [1:0]   act;
   logic [15:0] pend[$];
   int         k;

   initial begin
      clear_inputs();
      reset_n = 0;
      repeat (3) tick();
      reset_n = 1;
      @(negedge clock);
      chk("reset_outputs", {bus.accept, bus.ack, bus.mem_rd, bus.mem_wr, bus.mem_req_id}, '0);

      // single read from port 0
      tick();
      bus.rd[0] = 1; bus.addr[0] = 32'h10; bus.req_id[0] = 16'h0005;
      @(negedge clock);
      chk("single_accept", bus.accept, 2'b01);
      tick();
      bus.rd[0] = 0; bus.mem_accept = 1;
      @(negedge clock);
      chk("single_mem", {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_req_id},
          {1'b1, 16'h0000, 32'h10, 16'h0005});
      tick();
      bus.mem_accept = 0; bus.mem_ack = 1; bus.mem_resp_id = 16'h0005; bus.mem_read_data = RD0;
      tick();
      bus.mem_ack = 0; bus.mem_resp_id = 16'h8ab1; bus.mem_read_data = '1;
      @(negedge clock);
      chk("single_resp", {bus.ack, bus.resp_id[0], bus.read_data[0]}, {2'b01, 16'h0005, RD0});

      // tie from reset, core accepts but never acks
      reset_n = 0;
      clear_inputs();
      tick();
      tick();
      bus.rd[0] = 1; bus.req_id[0] = 16'h0001; bus.addr[0] = 32'h100;
      bus.rd[1] = 1; bus.req_id[1] = 16'h0003; bus.addr[1] = 32'h200;
      bus.mem_accept = 1;
      reset_n = 1;
      seen_p1_id = '0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clock);
         if (bus.accept != 2'b00) tie_q.push_back(bus.accept[1]);
         if (bus.mem_rd && bus.mem_req_id[15]) seen_p1_id = bus.mem_req_id;
         tick();
      end
      chk("tie_count", tie_q.size(), 4);
      chk("tie_order", {tie_q[0], tie_q[1], tie_q[2], tie_q[3]}, 4'b0101);
      chk("tie_p1_id", seen_p1_id, 16'h8003);
      @(negedge clock);
      chk("limit_blocked", bus.accept, 2'b00);
      tick();
      bus.mem_ack = 1; bus.mem_resp_id = 16'h0001;
      tick();
      bus.mem_ack = 0;
      cnt = 0; first_port = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (bus.accept != 2'b00) begin
            if (cnt == 0) first_port = bus.accept[1];
            cnt++;
         end
         tick();
      end
      chk("limit_one_more", cnt, 1);
      chk("limit_port", first_port, 1'b0);

      // backpressure on a port 1 write
      do_reset();
      bus.wr[1] = 16'h00ff; bus.rd[1] = 1; bus.addr[1] = 32'h20;
      bus.write_data[1] = WD1; bus.req_id[1] = 16'h0007;
      @(negedge clock);
      chk("bp_accept", bus.accept, 2'b10);
      tick();
      bus.wr[1] = '0; bus.rd[1] = 0;
      bus.rd[0] = 1; bus.addr[0] = 32'h30; bus.req_id[0] = 16'h0009;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("bp_stable", {bus.accept, bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_write_data, bus.mem_req_id},
             {2'b00, 16'h00ff, 1'b0, 32'h20, WD1, 16'h8007});
         tick();
      end
      bus.mem_accept = 1;
      @(negedge clock);
      tick();
      bus.mem_accept = 0;
      @(negedge clock);
      chk("bp_release", {bus.mem_wr, bus.mem_rd, bus.accept}, {16'h0000, 1'b0, 2'b01});
      tick();
      bus.rd[0] = 0;

      // reset while a request is presented
      @(negedge clock);
      chk("pre_reset_req", bus.mem_rd, 1'b1);
      #2 reset_n = 0;
      #1 chk("reset_async", {bus.mem_rd, bus.mem_wr, bus.accept, bus.ack}, '0);
      clear_inputs();
      tick();
      tick();
      bus.rd[0] = 1; bus.rd[1] = 1;
      reset_n = 1;
      @(negedge clock);
      chk("reset_first_tie", bus.accept, 2'b01);
`ifdef DDR3_ARB_STATS_EN
      chk("reset_stats", {bus.grants, bus.stall_cycles}, '0);
`endif
      tick();
      clear_inputs();
      tick();
      bus.mem_accept = 1;
      tick();
      bus.mem_accept = 0;

      // randomized traffic with a reactive core and protocol-following requesters
      act = 2'b00;
      pend.delete();
      for (int c = 0; c < 4000; c++) begin
         @(negedge clock);
         acc = bus.accept;
         tick();
         if (pend.size() > 0 && $urandom_range(0, 99) < 35) begin
            k = $urandom_range(0, pend.size() - 1);
            bus.mem_ack       = 1;
            bus.mem_resp_id   = pend[k];
            bus.mem_error     = ($urandom_range(0, 9) == 0);
            bus.mem_read_data = {$urandom, $urandom, $urandom, $urandom};
            pend.delete(k);
         end else begin
            bus.mem_ack       = 0;
            bus.mem_resp_id   = 16'($urandom);
            bus.mem_error     = 1'($urandom);
            bus.mem_read_data = {$urandom, $urandom, $urandom, $urandom};
         end
         if (bus.mem_rd || bus.mem_wr != '0) begin
            bus.mem_accept = ($urandom_range(0, 99) < 50);
            if (bus.mem_accept) pend.push_back(bus.mem_req_id);
         end else begin
            bus.mem_accept = ($urandom_range(0, 3) == 0);
         end
         for (int n = 0; n < 2; n++) begin
            if (act[n] && acc[n]) begin
               act[n] = 0; bus.rd[n] = 0; bus.wr[n] = '0;
            end else if (!act[n] && $urandom_range(0, 99) < 40) begin
               act[n]            = 1;
               bus.wr[n]         = $urandom_range(0, 1) ? 16'($urandom) : 16'h0000;
               bus.rd[n]         = 1'($urandom);
               if (!bus.rd[n] && bus.wr[n] == '0) bus.rd[n] = 1;
               bus.addr[n]       = $urandom;
               bus.write_data[n] = {$urandom, $urandom, $urandom, $urandom};
               bus.req_id[n]     = 16'($urandom);
            end
         end
      end
      @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
